// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the iterative RV32 M-extension execute unit.
package muldiv_unit_pkg;

    localparam int N_DEFAULT = 32;

    // funct3 encodings of the M-extension operations
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    // Control FSM states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_CALC = 2'd2,
        S_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/muldiv_step.sv
// Combinational W-bit add/subtract with carry-out, shared by the
// multiply accumulate step and the divide trial subtract.
module muldiv_step #(
    parameter int W = 33
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         sub_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);

    logic [W-1:0] b_eff;

    // Subtract as a + ~b + 1; carry-out set means a >= b (no borrow)
    always_comb begin
        b_eff           = sub_i ? ~b_i : b_i;
        {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_eff} + {{W{1'b0}}, sub_i};
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multi-cycle MUL/DIV unit: one bit per cycle, shift-add
// multiply and restoring divide on a shared 2N-bit accumulator.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int CW = $clog2(N) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         Start,
    input  logic [2:0]   Op,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Flush,
    output logic         Busy,
    output logic         Done,
    output logic [N-1:0] Result,
    output logic         ZeroFlag
);

    localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

    state_e         state_q;
    op_e            op_q;
    logic [N-1:0]   a_q, b_q, m_q, result_q;
    logic [2*N-1:0] acc_q, acc_d;
    logic [CW-1:0]  cnt_q;
    logic           neg_q, zero_q;

    logic           is_div, sa, sb, neg_d, spec_hit;
    logic [N-1:0]   mag_a, mag_b, spec_res, quo_fix, rem_fix, fin_res;
    logic [2*N-1:0] prod_fix;
    logic [N:0]     step_a, step_b, step_sum;
    logic           step_cout;

    assign is_div = op_q[2];

    // Adder operands: high half plus multiplicand, or shifted remainder minus divisor
    always_comb begin
        step_a = is_div ? {acc_q[2*N-1:N], acc_q[N-1]} : {1'b0, acc_q[2*N-1:N]};
        step_b = {1'b0, m_q};
    end

    muldiv_step #(.W(N + 1)) u_step (
        .a_i    (step_a),
        .b_i    (step_b),
        .sub_i  (is_div),
        .sum_o  (step_sum),
        .cout_o (step_cout)
    );

    // Operand magnitudes, special cases, next iteration and final sign fix
    always_comb begin
        sa    = a_q[N-1] & (op_q inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
        sb    = b_q[N-1] & (op_q inside {OP_MULH, OP_DIV, OP_REM});
        mag_a = sa ? -a_q : a_q;
        mag_b = sb ? -b_q : b_q;
        neg_d = (op_q == OP_REM) ? sa : (sa ^ sb);

        spec_hit = 1'b0;
        spec_res = '0;
        if (is_div && (b_q == '0)) begin
            spec_hit = 1'b1;
            spec_res = op_q[1] ? a_q : '1;
        end else if ((op_q inside {OP_DIV, OP_REM}) && (a_q == MIN_NEG) && (b_q == '1)) begin
            spec_hit = 1'b1;
            spec_res = op_q[1] ? '0 : a_q;
        end

        if (is_div)
            acc_d = step_cout ? {step_sum[N-1:0], acc_q[N-2:0], 1'b1}
                              : {step_a[N-1:0], acc_q[N-2:0], 1'b0};
        else
            acc_d = acc_q[0] ? {step_sum, acc_q[N-1:1]} : {1'b0, acc_q[2*N-1:1]};

        prod_fix = neg_q ? -acc_d : acc_d;
        quo_fix  = neg_q ? -acc_d[N-1:0] : acc_d[N-1:0];
        rem_fix  = neg_q ? -acc_d[2*N-1:N] : acc_d[2*N-1:N];

        case (op_q)
            OP_MUL:                       fin_res = prod_fix[N-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fin_res = prod_fix[2*N-1:N];
            OP_DIV, OP_DIVU:              fin_res = quo_fix;
            default:                      fin_res = rem_fix;
        endcase
    end

    // Control FSM with all datapath registers and registered result
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_MUL;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else if (Flush && (state_q != S_IDLE)) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (Start && !Flush) begin
                        a_q     <= A;
                        b_q     <= B;
                        op_q    <= op_e'(Op);
                        state_q <= S_PREP;
                    end
                end
                S_PREP: begin
                    cnt_q <= CW'(N);
                    neg_q <= neg_d;
                    if (spec_hit) begin
                        result_q <= spec_res;
                        zero_q   <= (spec_res == '0);
                        state_q  <= S_DONE;
                    end else begin
                        // multiply: multiplier in low half; divide: dividend in low half
                        m_q     <= is_div ? mag_b : mag_a;
                        acc_q   <= {{N{1'b0}}, (is_div ? mag_a : mag_b)};
                        state_q <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        result_q <= fin_res;
                        zero_q   <= (fin_res == '0);
                        state_q  <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Status decoded from the state register
    always_comb begin
        Busy     = (state_q != S_IDLE);
        Done     = (state_q == S_DONE);
        Result   = result_q;
        ZeroFlag = zero_q;
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, flush /
// start / reset sequences, and randomized ops against an arithmetic model.
module tb_muldiv_unit;

    localparam int N = 32;
    localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
    localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;
    localparam int LAT_CALC = N + 2;
    localparam int LAT_SPEC = 2;

    logic         clk, rst, Start, Flush, Busy, Done, ZeroFlag;
    logic [2:0]   Op;
    logic [N-1:0] A, B, Result;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    muldiv_unit #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .Start    (Start),
        .Op       (Op),
        .A        (A),
        .B        (B),
        .Flush    (Flush),
        .Busy     (Busy),
        .Done     (Done),
        .Result   (Result),
        .ZeroFlag (ZeroFlag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // RISC-V M semantics computed with wide integer arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        int ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        ia = $signed(a);
        ib = $signed(b);
        case (op)
            MUL:    begin p = sa * sb; return p[31:0];  end
            MULH:   begin p = sa * sb; return p[63:32]; end
            MULHSU: begin p = sa * ub; return p[63:32]; end
            MULHU:  begin p = ua * ub; return p[63:32]; end
            DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(ia / ib);
            end
            DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(ia % ib);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (op >= DIV && b == 0) return LAT_SPEC;
        if ((op == DIV || op == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return LAT_SPEC;
        return LAT_CALC;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op in the current cycle (cycle 0) and wait for Done
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string nm, output logic [31:0] res, output logic zf,
                          output int lat);
        logic busy_ok;
        Start = 1'b1;
        Op    = op;
        A     = a;
        B     = b;
        tick();
        Start = 1'b0;
        A     = $urandom;
        B     = $urandom;
        Op    = 3'($urandom);
        lat     = -1;
        busy_ok = 1'b1;
        res     = '0;
        zf      = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (!Busy) busy_ok = 1'b0;
            if (Done) begin
                lat = c;
                res = Result;
                zf  = ZeroFlag;
                break;
            end
            tick();
        end
        chk({nm, " busy"}, 64'(busy_ok), 64'd1);
        tick();
        chk({nm, " done_pulse"}, 64'({Done, Busy}), 64'd0);
    endtask

    vec_t        vecs[16];
    logic [31:0] res;
    logic        zf;
    int          lat;
    int          dones;
    logic [31:0] ra, rb;
    logic [2:0]  rop;

    initial begin
        rst = 1'b0; Start = 1'b0; Flush = 1'b0; Op = '0; A = '0; B = '0;

        vecs[0]  = '{MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT_CALC};
        vecs[1]  = '{MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, LAT_CALC};
        vecs[2]  = '{MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_CALC};
        vecs[3]  = '{MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT_CALC};
        vecs[4]  = '{DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, LAT_CALC};
        vecs[5]  = '{REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, LAT_CALC};
        vecs[6]  = '{DIVU,   32'd100,        32'd7,         32'd14,        LAT_CALC};
        vecs[7]  = '{REMU,   32'd100,        32'd7,         32'd2,         LAT_CALC};
        vecs[8]  = '{REM,    32'd6,          32'd3,         32'd0,         LAT_CALC};
        vecs[9]  = '{DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, LAT_SPEC};
        vecs[10] = '{REM,    32'd5,          32'd0,         32'd5,         LAT_SPEC};
        vecs[11] = '{DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, LAT_SPEC};
        vecs[12] = '{REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         LAT_SPEC};
        vecs[13] = '{DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, LAT_SPEC};
        vecs[14] = '{REMU,   32'd9,          32'd0,         32'd9,         LAT_SPEC};
        vecs[15] = '{MUL,    32'd0,          32'h1234_5678, 32'd0,         LAT_CALC};

        tick(); tick(); tick();
        chk("reset busy", 64'(Busy), 64'd0);
        chk("reset done", 64'(Done), 64'd0);
        chk("reset result", 64'(Result), 64'd0);
        chk("reset zero", 64'(ZeroFlag), 64'd0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, $sformatf("vec%0d", i), res, zf, lat);
            chk($sformatf("vec%0d result", i), 64'(res), 64'(vecs[i].exp));
            chk($sformatf("vec%0d zero", i), 64'(zf), 64'(vecs[i].exp == 0));
            chk($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].lat));
        end

        // Start together with Flush in IDLE is ignored
        Start = 1'b1; Flush = 1'b1; Op = MUL; A = 32'd3; B = 32'd3;
        tick();
        Start = 1'b0; Flush = 1'b0;
        chk("start_with_flush busy", 64'(Busy), 64'd0);

        // Flush in cycle 10 of a DIV, then Start in cycle 11
        run_op(DIVU, 32'd100, 32'd7, "pre_flush", res, zf, lat);
        chk("pre_flush result", 64'(res), 64'd14);
        dones = 0;
        Start = 1'b1; Op = DIV; A = 32'd1000; B = 32'd3;
        tick();
        Start = 1'b0;
        for (int c = 1; c < 10; c++) begin
            if (Done) dones++;
            tick();
        end
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        chk("flush busy", 64'(Busy), 64'd0);
        chk("flush done", 64'(Done), 64'd0);
        chk("flush result_kept", 64'(Result), 64'd14);
        chk("flush no_done", 64'(dones), 64'd0);
        run_op(MULHU, 32'hFFFF_FFFF, 32'h0000_0010, "after_flush", res, zf, lat);
        chk("after_flush result", 64'(res), 64'h0000_000F);
        chk("after_flush latency", 64'(lat), 64'(LAT_CALC));

        // Start while Busy and while in DONE is ignored
        dones = 0;
        res   = '0;
        Start = 1'b1; Op = MUL; A = 32'd3; B = 32'd5;
        tick();
        Start = 1'b0;
        for (int c = 1; c < 80; c++) begin
            if (c == 5) begin
                Start = 1'b1; Op = MUL; A = 32'd9; B = 32'd9;
            end else begin
                Start = 1'b0;
            end
            if (Done) begin
                dones++;
                res   = Result;
                Start = 1'b1; Op = MUL; A = 32'd11; B = 32'd11;
            end
            tick();
        end
        Start = 1'b0;
        chk("busy_start dones", 64'(dones), 64'd1);
        chk("busy_start result", 64'(res), 64'd15);
        chk("busy_start idle", 64'(Busy), 64'd0);

        // Reset in cycle 15 of a MUL
        dones = 0;
        Start = 1'b1; Op = MUL; A = 32'h1234; B = 32'h10;
        tick();
        Start = 1'b0;
        for (int c = 1; c < 15; c++) begin
            if (Done) dones++;
            tick();
        end
        rst = 1'b0;
        tick();
        chk("midreset busy", 64'(Busy), 64'd0);
        chk("midreset done", 64'(Done), 64'd0);
        chk("midreset result", 64'(Result), 64'd0);
        chk("midreset zero", 64'(ZeroFlag), 64'd0);
        rst = 1'b1;
        for (int c = 0; c < 50; c++) begin
            if (Done) dones++;
            tick();
        end
        chk("midreset no_done", 64'(dones), 64'd0);

        // Randomized ops against the arithmetic model
        for (int i = 0; i < 250; i++) begin
            rop = 3'($urandom);
            ra  = pick_operand();
            rb  = pick_operand();
            run_op(rop, ra, rb, $sformatf("rand%0d", i), res, zf, lat);
            chk($sformatf("rand%0d op%0d a=%h b=%h result", i, rop, ra, rb),
                64'(res), 64'(ref_model(rop, ra, rb)));
            chk($sformatf("rand%0d zero", i), 64'(zf), 64'(ref_model(rop, ra, rb) == 0));
            chk($sformatf("rand%0d latency", i), 64'(lat), 64'(ref_latency(rop, ra, rb)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
